register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 19 +
 rtl/register_file_clear_ctrl.sv | 56 +++++
 rtl/register_file.sv | 71 +++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared types and helpers for the register file and its clear-sweep controller.
package register_file_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  // Ceiling log2, used to size address ports from DEPTH at elaboration time.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/register_file_clear_ctrl.sv
// Clear-sweep controller: walks every register once, zeroing one entry per
// cycle, and reports busy for the whole sweep.
module register_file_clear_ctrl
  import register_file_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = log2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          clear,
  output logic          busy,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns the next state; no latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == CLEARING);
  assign sweep_we   = busy;
  assign sweep_addr = cnt_q;

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with byte enables, optional write-to-read
// forwarding, and a multi-cycle clear sweep.
module register_file
  import register_file_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 8,
  parameter  int BYPASS = 1,
  localparam int AW     = log2(DEPTH),
  localparam int NB     = WIDTH / 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             writeEnable,
  input  logic [AW-1:0]    writeAddr,
  input  logic [WIDTH-1:0] write,
  input  logic [NB-1:0]    byteEnable,
  input  logic             clear,
  input  logic [AW-1:0]    readAddrA,
  input  logic [AW-1:0]    readAddrB,
  output logic [WIDTH-1:0] readA,
  output logic [WIDTH-1:0] readB,
  output logic             busy
);

  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] wr_merged_d;
  logic             wr_fire;
  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;

  register_file_clear_ctrl #(
    .DEPTH (DEPTH)
  ) u_clear_ctrl (
    .clk        (clk),
    .resetN     (resetN),
    .clear      (clear),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // A clear request or an active sweep both swallow the write.
  assign wr_fire = writeEnable && !clear && !busy;

  always_comb begin
    wr_merged_d = mem_q[writeAddr];
    for (int b = 0; b < NB; b++) begin
      if (byteEnable[b]) wr_merged_d[8*b +: 8] = write[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: the array is reset on purpose; reads must return 0 right after reset.
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (sweep_we) begin
      mem_q[sweep_addr] <= '0;
    end else if (wr_fire) begin
      mem_q[writeAddr] <= wr_merged_d;
    end
  end

  assign readA = (BYPASS_EN && wr_fire && (readAddrA == writeAddr)) ? wr_merged_d
                                                                    : mem_q[readAddrA];
  assign readB = (BYPASS_EN && wr_fire && (readAddrB == writeAddr)) ? wr_merged_d
                                                                    : mem_q[readAddrB];

endmodule
